vm_controller: RTL and testbench

// Central sequencer of the vending machine. Accumulates inserted coins into a credit register,

---
 rtl/vm_controller.sv | 172 +++++++++++++++++
 tb/tb_vm_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_controller.sv
// Vending machine sequencer: coin credit accumulation, purchase acceptance,
// dispenser handshake, and greedy one-coin-per-cycle change payout from stock.
module vm_controller #(
    parameter int unsigned NUM_PRODUCTS = 10,
    parameter int unsigned PRICE_STEP   = 5,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned COIN_CNT_W   = 6,
    parameter int unsigned CHANGE_INIT  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] money,
    input  logic       money_valid,
    input  logic [3:0] product_code,
    input  logic       buy,
    input  logic       product_ready,
    output logic [3:0] ready_product_code,
    output logic       product_valid,
    output logic       busy,
    output logic [3:0] change_denomination_code,
    output logic       change_valid,
    output logic       no_change
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    localparam int unsigned PW = CREDIT_W + 8;
    localparam logic [CREDIT_W-1:0]   CREDIT_MAX = '1;
    localparam logic [COIN_CNT_W-1:0] STOCK_MAX  = '1;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CREDIT_W-1:0]   credit;
    logic [COIN_CNT_W-1:0] stock [1:6];
    logic [3:0]            vend_code;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] code);
        case (code)
            4'd1:    coin_value = CREDIT_W'(1);
            4'd2:    coin_value = CREDIT_W'(2);
            4'd3:    coin_value = CREDIT_W'(5);
            4'd4:    coin_value = CREDIT_W'(10);
            4'd5:    coin_value = CREDIT_W'(20);
            4'd6:    coin_value = CREDIT_W'(50);
            default: coin_value = '0;
        endcase
    endfunction

    // Purchase qualification
    logic [PW-1:0] price;
    logic          code_valid;
    logic          buy_ok;

    assign price      = (PW'(product_code) + PW'(1)) * PW'(PRICE_STEP);
    assign code_valid = 32'(product_code) < NUM_PRODUCTS;
    assign buy_ok     = buy && code_valid && (PW'(credit) >= price);

    // A coin is accepted only when no buy is presented and the sum stays in range
    logic [CREDIT_W-1:0] money_value;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;

    assign money_value = coin_value(money);
    assign coin_sum    = {1'b0, credit} + {1'b0, money_value};
    assign coin_ok     = money_valid && !buy && (money_value != '0)
                         && (coin_sum <= {1'b0, CREDIT_MAX});

    // Greedy change selection: largest denomination that fits and is in stock
    logic                chg_found;
    logic [3:0]          chg_code;
    logic [CREDIT_W-1:0] chg_value;

    always_comb begin
        chg_found = 1'b0;
        chg_code  = 4'd0;
        for (int i = 6; i >= 1; i--) begin
            if (!chg_found && (coin_value(4'(i)) <= credit) && (stock[i] != '0)) begin
                chg_found = 1'b1;
                chg_code  = 4'(i);
            end
        end
    end

    assign chg_value = coin_value(chg_code);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (buy_ok) begin
                    state_next = S_VEND;
                end
            end
            S_VEND: begin
                if (product_ready) begin
                    state_next = S_CHANGE;
                end
            end
            S_CHANGE: begin
                if ((credit == '0) || !chg_found) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            busy                     <= 1'b0;
            credit                   <= '0;
            vend_code                <= 4'd0;
            ready_product_code       <= 4'd0;
            product_valid            <= 1'b0;
            change_denomination_code <= 4'd0;
            change_valid             <= 1'b0;
            no_change                <= 1'b0;
            for (int i = 1; i <= 6; i++) begin
                stock[i] <= COIN_CNT_W'(CHANGE_INIT);
            end
        end else begin
            state         <= state_next;
            busy          <= (state_next != S_IDLE);
            product_valid <= 1'b0;
            change_valid  <= 1'b0;
            no_change     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (buy_ok) begin
                        credit    <= credit - price[CREDIT_W-1:0];
                        vend_code <= product_code;
                    end else if (coin_ok) begin
                        credit <= coin_sum[CREDIT_W-1:0];
                        for (int i = 1; i <= 6; i++) begin
                            if ((money == 4'(i)) && (stock[i] != STOCK_MAX)) begin
                                stock[i] <= stock[i] + COIN_CNT_W'(1);
                            end
                        end
                    end
                end
                S_VEND: begin
                    if (product_ready) begin
                        product_valid      <= 1'b1;
                        ready_product_code <= vend_code;
                    end
                end
                S_CHANGE: begin
                    if (credit != '0) begin
                        if (chg_found) begin
                            change_valid             <= 1'b1;
                            change_denomination_code <= chg_code;
                            credit                   <= credit - chg_value;
                            for (int i = 1; i <= 6; i++) begin
                                if (chg_code == 4'(i)) begin
                                    stock[i] <= stock[i] - COIN_CNT_W'(1);
                                end
                            end
                        end else begin
                            // Remaining credit stays for a later purchase
                            no_change <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_controller.sv
// Bench for vm_controller: directed scenarios plus randomized purchases checked
// against a transaction-level model of credit, stock and greedy change.
module tb_vm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] money = 4'd0;
  logic       money_valid = 1'b0;
  logic [3:0] product_code = 4'd0;
  logic       buy = 1'b0;
  logic       product_ready = 1'b0;
  logic       use_b = 1'b0;

  logic [3:0] rpc_a, cdc_a, rpc_b, cdc_b;
  logic       pv_a, busy_a, cv_a, nc_a, pv_b, busy_b, cv_b, nc_b;

  always #5 clk = ~clk;

  vm_controller u_dut_a (
    .clk(clk), .rst(rst), .money(money), .money_valid(money_valid),
    .product_code(product_code), .buy(buy), .product_ready(product_ready),
    .ready_product_code(rpc_a), .product_valid(pv_a), .busy(busy_a),
    .change_denomination_code(cdc_a), .change_valid(cv_a), .no_change(nc_a)
  );

  vm_controller #(.CHANGE_INIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .money(money), .money_valid(money_valid),
    .product_code(product_code), .buy(buy), .product_ready(product_ready),
    .ready_product_code(rpc_b), .product_valid(pv_b), .busy(busy_b),
    .change_denomination_code(cdc_b), .change_valid(cv_b), .no_change(nc_b)
  );

  logic [3:0] o_rpc, o_cdc;
  logic       o_pv, o_busy, o_cv, o_nc;
  assign o_rpc  = use_b ? rpc_b  : rpc_a;
  assign o_cdc  = use_b ? cdc_b  : cdc_a;
  assign o_pv   = use_b ? pv_b   : pv_a;
  assign o_busy = use_b ? busy_b : busy_a;
  assign o_cv   = use_b ? cv_b   : cv_a;
  assign o_nc   = use_b ? nc_b   : nc_a;

  // Reference model state
  int         credit;
  int         stock [1:6];
  int         init_stock;
  logic [3:0] exp_rpc;
  logic [3:0] exp_cdc;

  int checks = 0;
  int errors = 0;

  function automatic int coin_val(input int code);
    case (code)
      1: return 1;
      2: return 2;
      3: return 5;
      4: return 10;
      5: return 20;
      6: return 50;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cycle_check(input string tag, input bit e_pv, input bit e_cv,
                             input bit e_nc, input bit e_busy);
    chk({tag, "/busy"}, 8'(o_busy), 8'(e_busy));
    chk({tag, "/product_valid"}, 8'(o_pv), 8'(e_pv));
    chk({tag, "/change_valid"}, 8'(o_cv), 8'(e_cv));
    chk({tag, "/no_change"}, 8'(o_nc), 8'(e_nc));
    chk({tag, "/ready_code"}, 8'(o_rpc), 8'(exp_rpc));
    chk({tag, "/change_code"}, 8'(o_cdc), 8'(exp_cdc));
  endtask

  task automatic model_reset();
    credit  = 0;
    exp_rpc = 4'd0;
    exp_cdc = 4'd0;
    for (int i = 1; i <= 6; i++) stock[i] = init_stock;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    money_valid = 1'b0;
    buy = 1'b0;
    product_ready = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    cycle_check(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic insert(input int code);
    int v;
    money = 4'(code);
    money_valid = 1'b1;
    step();
    money_valid = 1'b0;
    v = coin_val(code);
    if (v > 0 && credit + v <= 255) begin
      credit += v;
      if (stock[code] < 63) stock[code]++;
    end
    cycle_check("coin", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // abort_at: -1 none, 0 reset while waiting in VEND, n>0 reset after n change coins
  task automatic purchase(input int code, input int waits, input bit junk,
                          input bit with_coin, input int abort_at);
    int price;
    int rem;
    logic [3:0] exp_q[$];
    product_code = 4'(code);
    buy = 1'b1;
    if (with_coin) begin
      money = 4'd4;
      money_valid = 1'b1;
    end
    step();
    buy = 1'b0;
    money_valid = 1'b0;
    price = (code + 1) * 5;
    if (!(code < 10 && credit >= price)) begin
      cycle_check("buy_rejected", 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    credit -= price;
    cycle_check("buy_accepted", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < waits; w++) begin
      if (junk) begin
        money = 4'($urandom_range(1, 6));
        money_valid = 1'b1;
        buy = 1'b1;
        product_code = 4'($urandom_range(0, 9));
      end
      step();
      money_valid = 1'b0;
      buy = 1'b0;
      cycle_check("vend_wait", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if (abort_at == 0) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      cycle_check("abort_vend", 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    product_ready = 1'b1;
    step();
    product_ready = 1'b0;
    exp_rpc = 4'(code);
    cycle_check("product", 1'b1, 1'b0, 1'b0, 1'b1);
    rem = credit;
    for (int c = 6; c >= 1; c--) begin
      while (rem >= coin_val(c) && stock[c] > 0) begin
        exp_q.push_back(4'(c));
        rem -= coin_val(c);
        stock[c]--;
      end
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        cycle_check("abort_change", 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      step();
      exp_cdc = exp_q[n];
      cycle_check("change", 1'b0, 1'b1, 1'b0, 1'b1);
    end
    credit = rem;
    step();
    if (rem > 0) cycle_check("no_change", 1'b0, 1'b0, 1'b1, 1'b0);
    else         cycle_check("done", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    init_stock = 10;
    model_reset();
    repeat (2) step();
    do_reset("reset");

    // Single change coin after product
    insert(5);
    purchase(2, 3, 1'b0, 1'b0, -1);

    // 45 change paid as 20, 20, 5
    insert(6);
    purchase(0, 1, 1'b0, 1'b0, -1);

    // Insufficient credit, then topped up
    insert(4);
    purchase(3, 1, 1'b0, 1'b0, -1);
    insert(4);
    purchase(3, 2, 1'b0, 1'b0, -1);

    // Coin presented together with buy is dropped
    insert(4);
    purchase(0, 1, 1'b0, 1'b1, -1);

    // Coins and buys while vending are dropped
    insert(5);
    purchase(1, 4, 1'b1, 1'b0, -1);

    // Invalid coin codes and invalid product codes
    insert(7);
    insert(0);
    insert(15);
    purchase(0, 0, 1'b0, 1'b0, -1);
    insert(6);
    purchase(10, 0, 1'b0, 1'b0, -1);
    purchase(15, 0, 1'b0, 1'b0, -1);
    purchase(9, 0, 1'b0, 1'b0, -1);

    // Credit saturation boundary
    for (int k = 0; k < 5; k++) insert(6);
    insert(4);
    insert(3);
    purchase(9, 2, 1'b0, 1'b0, -1);

    // Reset while vending, then a clean purchase
    insert(4);
    purchase(0, 2, 1'b0, 1'b0, 0);
    insert(3);
    purchase(0, 1, 1'b0, 1'b0, -1);

    // Reset in the middle of change payout
    insert(6);
    purchase(0, 1, 1'b0, 1'b0, 1);
    insert(5);
    purchase(2, 0, 1'b0, 1'b0, -1);

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) insert($urandom_range(0, 9));
      purchase($urandom_range(0, 11), $urandom_range(0, 3),
               ($urandom_range(0, 1) == 1), 1'b0, -1);
    end

    // Empty change stock: no_change with credit retained
    use_b = 1'b1;
    init_stock = 0;
    do_reset("reset_b");
    insert(4);
    purchase(0, 1, 1'b0, 1'b0, -1);
    purchase(0, 1, 1'b0, 1'b0, -1);
    insert(5);
    insert(5);
    purchase(0, 2, 1'b0, 1'b0, -1);
    purchase(1, 0, 1'b0, 1'b0, -1);
    purchase(0, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) insert($urandom_range(1, 6));
      purchase($urandom_range(0, 9), $urandom_range(0, 2), 1'b0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
